// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the board SRAM arbiter.
//   state_e          access sequencer states
//   PORT_A / PORT_B  requester indices (also the encoding of last_grant)
//   *_DEF            default geometry of the 2K x 8 SRAM and strobe length
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int ADDR_W_DEF        = 11;
    localparam int DATA_W_DEF        = 8;
    localparam int STROBE_CYCLES_DEF = 1;

endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: two-way grant selector.
//   a_req, b_req   pending requests
//   last_grant     port granted most recently (PORT_A / PORT_B)
//   grant_valid    at least one request pending
//   grant          winning port
// Build option SRAM_ARB_FIXED_PRIO_EN: port A always wins a tie and
// last_grant is ignored (B may starve). Default: round-robin on ties.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);

    assign grant_valid = a_req | b_req;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign grant = a_req ? PORT_A : PORT_B;
`else
    always_comb begin
        grant = PORT_A;
        if (a_req && b_req) begin
            grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (b_req) begin
            grant = PORT_B;
        end
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single-port board SRAM between port A (processor
// PIO) and port B (serial receive logger). Each access runs a fixed
// SETUP / STROBE / DONE sequence with registered active-low strobes.
//   clk, reset          system clock, synchronous active-low reset
//   a_*, b_*            req/ack requester ports; rdata held until next read
//   mem_*               SRAM address, data and strobes; mem_drive enables
//                       the top-level data-bus tristate
//   busy                sequencer not in IDLE
// Build option SRAM_ARB_FIXED_PRIO_EN: fixed priority to A (see sram_arb_pick).
//
// state  | meaning
// IDLE   | bus released, sample requests and grant
// SETUP  | chip select asserted, write data driven, strobes high
// STROBE | OE or WE low for STROBE_CYCLES cycles
// DONE   | strobes high, CS and write data held, ack to granted port
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int STROBE_CYCLES = STROBE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_drive,
    output logic              mem_cs_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic              busy
);

    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              grant_q, grant_d;
    logic              op_we_q, op_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cs_n_q, cs_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              drive_q, drive_d;
    logic              busy_q, busy_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              last_grant;
    logic              pick_valid;
    logic              pick_port;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign last_grant = PORT_B;
`else
    logic last_grant_q, last_grant_d;
    assign last_grant = last_grant_q;
`endif

    sram_arb_pick u_pick (
        .a_req       (a_req),
        .b_req       (b_req),
        .last_grant  (last_grant),
        .grant_valid (pick_valid),
        .grant       (pick_port)
    );

    // Outputs are computed from the next state so every strobe is a flop
    // output that lines up with the state it belongs to.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        op_we_d   = op_we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cs_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        drive_d   = 1'b0;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = SETUP;
                    grant_d = pick_port;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    last_grant_d = pick_port;
`endif
                    if (pick_port == PORT_A) begin
                        op_we_d = a_we;
                        addr_d  = a_addr;
                        wdata_d = a_wdata;
                    end else begin
                        op_we_d = b_we;
                        addr_d  = b_addr;
                        wdata_d = b_wdata;
                    end
                    cs_n_d  = 1'b0;
                    drive_d = op_we_d;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = STROBE_LOAD;
                cs_n_d  = 1'b0;
                drive_d = op_we_q;
                we_n_d  = ~op_we_q;
                oe_n_d  = op_we_q;
            end
            STROBE: begin
                cs_n_d  = 1'b0;
                drive_d = op_we_q;
                if (cnt_q == 4'd0) begin
                    // Last strobe cycle: data is sampled while OE is still low.
                    state_d = DONE;
                    a_ack_d = (grant_q == PORT_A);
                    b_ack_d = (grant_q == PORT_B);
                    if (!op_we_q) begin
                        if (grant_q == PORT_A) a_rdata_d = mem_rdata;
                        else                   b_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    we_n_d = ~op_we_q;
                    oe_n_d = op_we_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            grant_q   <= PORT_A;
            op_we_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cs_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            drive_q   <= 1'b0;
            busy_q    <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_grant_q <= PORT_B;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            op_we_q   <= op_we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cs_n_q    <= cs_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            drive_q   <= drive_d;
            busy_q    <= busy_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_drive = drive_q;
    assign mem_cs_n  = cs_n_q;
    assign mem_oe_n  = oe_n_q;
    assign mem_we_n  = we_n_q;
    assign busy      = busy_q;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sequences and shares the single-port 2K x 8 board SRAM between two requesters: port A (Nios II PIO side) and port B (serial receive logger writing incoming characters). Converts a simple req/ack handshake into a fixed-length SRAM cycle with registered active-low chip-select, output-enable and write-enable strobes. Sits between the processor/serial glue and the SRAM model; top level performs data-bus tristating using `mem_drive`.

## Interface
- `ADDR_W`, 11, SRAM address width
- `DATA_W`, 8, SRAM data width
- `STROBE_CYCLES`, 1, cycles `mem_oe_n`/`mem_we_n` held low; legal 1..15

- `clk` in 1 system clock; all logic on rising edge
- `reset` in 1 reset; synchronous, active-low
- `a_req`, `b_req` in 1 access request, level, held until ack
- `a_we`, `b_we` in 1 1 = write, 0 = read; stable while req high
- `a_addr`, `b_addr` in ADDR_W address; stable while req high
- `a_wdata`, `b_wdata` in DATA_W write data; stable while req high
- `a_ack`, `b_ack` out 1 one-cycle completion pulse
- `a_rdata`, `b_rdata` out DATA_W read result, valid from ack, held until that port's next read completes
- `mem_addr` out ADDR_W SRAM address
- `mem_wdata` out DATA_W SRAM write data
- `mem_rdata` in DATA_W SRAM read data
- `mem_drive` out 1 top level drives SRAM data bus when 1
- `mem_cs_n`, `mem_oe_n`, `mem_we_n` out 1 SRAM strobes, active-low
- `busy` out 1 high in any state other than IDLE

## Operation
- FSM: IDLE -> SETUP -> STROBE -> DONE -> IDLE.
- IDLE: sample requests. If none, stay. If one, grant it. If both, round-robin: grant the port not granted last. `last_grant` resets to B, so A wins the first tie.
- Grant: latch the winner's `addr`, `we` and `wdata` into `mem_addr`, `mem_wdata` and an internal `op_we`. Then go to SETUP.
- SETUP, 1 cycle: `mem_cs_n` = 0. If write, `mem_drive` = 1. Strobes stay high.
- STROBE, `STROBE_CYCLES` cycles, counted by a 4-bit down-counter: `mem_we_n` = 0 for writes, or `mem_oe_n` = 0 for reads.
  - On the edge leaving the last STROBE cycle, a read latches `mem_rdata` into the granted port's rdata register.
- DONE, 1 cycle: strobes high, `mem_cs_n` stays 0, `mem_drive` stays at its write value (gives data hold). Granted port's ack = 1.
- Then IDLE for at least 1 cycle, with `mem_cs_n` = 1 and `mem_drive` = 0 (bus turnaround).
- Requester must drop req on the edge where it samples ack = 1. Requests arriving during a non-IDLE state wait; they are never dropped.
- Reset at any point: on the next edge, FSM = IDLE and an in-flight access is abandoned with no ack. Reset values:
  - `mem_cs_n` = `mem_oe_n` = `mem_we_n` = 1
  - `mem_drive` = 0, `busy` = 0
  - `mem_addr` = 0, `mem_wdata` = 0
  - both acks 0, both rdata 0
  - counter 0, `last_grant` = B

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Request seen in IDLE at edge 0: SETUP in cycle 1, STROBE in cycles 2..1+`STROBE_CYCLES`, ack high in cycle 2+`STROBE_CYCLES`.
- Request-to-ack latency: 3 cycles at the default.
- Back-to-back throughput: one access every 3+`STROBE_CYCLES` cycles (4 at the default).
- Both ports requesting continuously alternate A, B, A, B.

## Configuration
- `SRAM_ARB_FIXED_PRIO_EN` defined: port A always wins a tie. `last_grant` is not implemented, and B can starve.
- Not defined: round-robin as described in Operation.

## Structure
- Package `sram_arb_pkg` holds:
  - state enum (IDLE, SETUP, STROBE, DONE)
  - port index constants `PORT_A` = 0, `PORT_B` = 1
  - default widths
- One sub-module `sram_arb_pick`: 2-input grant selector taking both reqs and `last_grant`, returning the winner. The macro option lives here.

## Test plan
- Reset then A write addr 0x012, data 0x5A: `mem_we_n` low exactly cycle 2, `a_ack` in cycle 3, `mem_drive` high in cycles 1–3; B read of 0x012 then returns `b_rdata` = 0x5A.
- A and B request in the same cycle: A is served first, then B; both requests held high continuously give ack order A, B, A, B.
- Same as above with `SRAM_ARB_FIXED_PRIO_EN` defined: B gets no ack while A requests continuously; B is served once A drops.
- `STROBE_CYCLES` = 3, read addr 0x7FF containing 0xC3: `mem_oe_n` low for 3 cycles, ack at cycle 5, rdata = 0xC3.
- Reset asserted during STROBE of a write: next edge all strobes high, `mem_drive` = 0, `busy` = 0, no ack ever issued for that access.
- Req raised in DONE cycle of a prior access: not sampled until IDLE; `mem_cs_n` high for at least 1 cycle between the two accesses.
